// File: rtl/ram_n.sv
// ram_n: parametrised word-addressable RAM, combinational read, clocked write.
// Optional post-reset clear sweep with busy status, enabled by RAM_N_CLEAR_EN.
module ram_n #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  in,
    output logic [WIDTH-1:0]  out,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];

`ifdef RAM_N_CLEAR_EN

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nx_c;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nx_c;
    logic              wr_en_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [WIDTH-1:0]  wr_data_c;

    // State and clear pointer; reset restarts the sweep from word 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nx_c;
            ptr   <= ptr_nx_c;
        end
    end

    // Next state and write-port steering: sweep writes zeros, idle takes load
    always_comb begin
        state_nx_c = state;
        ptr_nx_c   = ptr;
        wr_en_c    = 1'b0;
        wr_addr_c  = address;
        wr_data_c  = in;
        case (state)
            ST_CLEAR: begin
                wr_en_c   = 1'b1;
                wr_addr_c = ptr;
                wr_data_c = '0;
                if (ptr == ADDR_W'(DEPTH - 1)) begin
                    state_nx_c = ST_IDLE;
                end else begin
                    ptr_nx_c = ptr + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                wr_en_c = load;
            end
            default: begin
                state_nx_c = ST_CLEAR;
                ptr_nx_c   = '0;
            end
        endcase
    end

    // Array write; while reset is held the flops sit at CLEAR/ptr=0, so the
    // only write that can land is zero into word 0, which the sweep clears anyway
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_addr_c] <= wr_data_c;
        end
    end

    assign busy = (state == ST_CLEAR);
    assign out  = busy ? '0 : mem[address];

`else

    // Reset has no effect on the plain array
    logic unused_reset;
    assign unused_reset = reset;

    // Array write on load from the first edge
    always_ff @(posedge clk) begin
        if (load) begin
            mem[address] <= in;
        end
    end

    assign busy = 1'b0;
    assign out  = mem[address];

`endif

endmodule

// File: tb/tb_ram_n.sv
// Testbench for ram_n: behavioural model plus directed vectors.
// Covers both builds of RAM_N_CLEAR_EN.
module tb_ram_n;

`ifdef RAM_N_CLEAR_EN
    localparam int unsigned W = 16;
    localparam int unsigned A = 3;
    localparam bit CLR = 1'b1;
`else
    localparam int unsigned W = 8;
    localparam int unsigned A = 4;
    localparam bit CLR = 1'b0;
`endif
    localparam int unsigned D = 2 ** A;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [A-1:0] address;
    logic [W-1:0] in;
    logic [W-1:0] out;
    logic         busy;

    int total = 0;
    int bad   = 0;

    // Model: expected contents, known flags, edges of clear sweep remaining
    logic [W-1:0] m_mem [D];
    bit           m_known [D];
    int           m_sweep = 0;

    ram_n #(.WIDTH(W), .ADDR_W(A)) dut (
        .clk    (clk),
        .reset  (rst),
        .load   (load),
        .address(address),
        .in     (in),
        .out    (out),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < D; i++) m_known[i] = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: reset zeroes everything and demands a full sweep; writes dropped while sweeping
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            if (CLR) begin
                m_sweep = D;
                for (int i = 0; i < D; i++) begin
                    m_mem[i]   = '0;
                    m_known[i] = 1'b1;
                end
            end
        end else if (m_sweep > 0) begin
            m_sweep--;
        end else if (load) begin
            m_mem[address]   = in;
            m_known[address] = 1'b1;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        chk("busy_model", 32'(busy), 32'(m_sweep != 0));
        if (m_sweep != 0)
            chk("out_busy_zero", 32'(out), 32'h0);
        else if (m_known[address])
            chk("out_model", 32'(out), 32'(m_mem[address]));
    end

    // Inputs change at posedge+2, away from both edges
    task automatic write_word(input logic [A-1:0] a, input logic [W-1:0] d);
        address = a;
        in      = d;
        load    = 1'b1;
        @(posedge clk);
        #2 load = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [A-1:0] a, input logic [W-1:0] exp);
        address = a;
        #1 chk(name, 32'(out), 32'(exp));
        @(posedge clk);
        #2;
    endtask

    // Count edges until busy falls, bounded; leaves load low, phase posedge+2
    task automatic sweep_len(input string name);
        int n;
        n = 0;
        for (int i = 0; i < 4 * D + 8; i++) begin
            @(posedge clk);
            #1 n++;
            if (!busy) break;
        end
        load = 1'b0;
        #1 chk(name, 32'(n), 32'(D));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load = 1'b0; address = '0; in = '0;
`ifdef RAM_N_CLEAR_EN
        #1 chk("rst_busy", 32'(busy), 32'h1);
        chk("rst_out", 32'(out), 32'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        // Reset sweep with load held high: nothing may be accepted
        address = 3'd0; in = 16'hDEAD; load = 1'b1;
        sweep_len("sweep_first");
        for (int i = 0; i < D; i++) read_chk("swept_zero", A'(i), 16'h0000);

        // Basic write/read
        write_word(3'd5, 16'hBEEF);
        write_word(3'd2, 16'h1234);
        for (int i = 0; i < D; i++)
            read_chk("basic_rd", A'(i), (i == 5) ? 16'hBEEF : (i == 2) ? 16'h1234 : 16'h0000);

        // Same-cycle write/read of one address: old before edge, new after
        address = 3'd5; in = 16'h7777; load = 1'b1;
        #1 chk("rw_old", 32'(out), 32'hBEEF);
        @(posedge clk);
        #1 chk("rw_new", 32'(out), 32'h7777);
        #1 load = 1'b0;

        // Combinational address change with no clock
        address = 3'd2;
        #1 chk("addr_comb", 32'(out), 32'h1234);
        #1;

        // Load gating
        address = 3'd3; in = 16'hFFFF; load = 1'b0;
        repeat (4) @(posedge clk);
        #2 read_chk("gate_off", 3'd3, 16'h0000);
        write_word(3'd3, 16'hFFFF);
        read_chk("gate_on", 3'd3, 16'hFFFF);

        // Reset mid-sweep restarts the full sweep
        rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("mid_busy", 32'(busy), 32'h1);
        chk("mid_out", 32'(out), 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        sweep_len("sweep_mid");
        #1;

        // Reset after use clears every word
        for (int i = 0; i < D; i++) write_word(A'(i), 16'hA000 + 16'(i));
        read_chk("fill_rd6", 3'd6, 16'hA006);
        address = 3'd3;
        #1 chk("pre_rst_out", 32'(out), 32'hA003);
        #1 rst = 1'b1;
        #1 chk("use_rst_out", 32'(out), 32'h0);
        chk("use_rst_busy", 32'(busy), 32'h1);
        @(posedge clk);
        #2 rst = 1'b0;
        sweep_len("sweep_use");
        #1;
        for (int i = 0; i < D; i++) read_chk("use_zero", A'(i), 16'h0000);
`else
        #1 chk("busy_t0", 32'(busy), 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        write_word(4'd15, 8'h5A);
        read_chk("first_wr", 4'd15, 8'h5A);
        // Reset pulse leaves contents alone
        address = 4'd15;
        rst = 1'b1;
        #1 chk("rst_keep_busy", 32'(busy), 32'h0);
        chk("rst_keep_out", 32'(out), 32'h5A);
        @(posedge clk);
        #2 rst = 1'b0;
        read_chk("after_rst", 4'd15, 8'h5A);
        write_word(4'd0, 8'h11);
        write_word(4'd7, 8'hC3);
        read_chk("rd0", 4'd0, 8'h11);
        read_chk("rd7", 4'd7, 8'hC3);
        read_chk("rd15", 4'd15, 8'h5A);
        // Same-cycle write/read and load gating
        address = 4'd7; in = 8'h3C; load = 1'b1;
        #1 chk("rw_old", 32'(out), 32'hC3);
        @(posedge clk);
        #1 chk("rw_new", 32'(out), 32'h3C);
        #1 load = 1'b0;
        address = 4'd0; in = 8'hFF;
        repeat (4) @(posedge clk);
        #2 read_chk("gate_off", 4'd0, 8'h11);
        write_word(4'd0, 8'hFF);
        read_chk("gate_on", 4'd0, 8'hFF);
`endif
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
